bram_bus_wrapper: RTL
=====================

Name: bram_bus_wrapper

Overview:
Parametrised single-port block-RAM slave for the SoC memory bus. It replaces the fixed 32-bit wrapper and adds:
- byte-lane write strobes
- base/range address decode with error reporting
- configurable read latency with a read-valid pulse
- read/write collision handling through a one-deep pending-read slot
- optional zero-fill of the whole array after reset

The memory array is inferred inside the block, so no vendor IP core is needed.

Parameters:
DATA_W, 32, data width in bits; multiple of 8
ADDR_W, 32, bus address width
DEPTH, 4096, number of DATA_W words; power of two
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*DATA_W/8
READ_LAT, 1, cycles from accepted read to o_RValid; legal values 1 or 2 (2 adds an output register)
CLEAR_ON_RST, 1, 1 = zero-fill the array after reset; 0 = no fill

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  reset; synchronous, active-high
i_WEnable  in  1  write request
i_WAddr  in  ADDR_W  write byte address
i_WData  in  DATA_W  write data
i_WStrb  in  DATA_W/8  byte-lane write enables
i_REnable  in  1  read request
i_RAddr  in  ADDR_W  read byte address
o_RData  out  DATA_W  read data; holds its value until the next o_RValid
o_RValid  out  1  one-cycle pulse marking valid o_RData
o_Err  out  1  one-cycle error pulse
o_MemBusy  out  1  requests are ignored while high

Behaviour:
- One clock (i_Clk). Reset i_Rst is synchronous and active-high.
- Reset values: o_RData=0, o_RValid=0, o_Err=0, o_MemBusy=1. All pipeline valids and the pending slot are cleared.
- Address decode:
  - word index = (addr - BASE_ADDR) >> log2(DATA_W/8)
  - an address is legal if it lies in [BASE_ADDR, BASE_ADDR + DEPTH*DATA_W/8) and is word-aligned
- FSM states: CLEAR, IDLE, PEND.
  - Reset → CLEAR if CLEAR_ON_RST=1, otherwise → IDLE.
  - CLEAR: writes 0 to one word per cycle, index 0 to DEPTH-1; o_MemBusy=1; → IDLE after the last word. Total is DEPTH cycles, so o_MemBusy falls on the cycle after word DEPTH-1 is written.
  - IDLE: o_MemBusy=0.
    - Write only: legal → the lanes set in i_WStrb are written at the clock edge; illegal → memory unchanged and o_Err pulses on the next cycle.
    - Read only: legal → array read issued; o_RValid pulses READ_LAT cycles later. Illegal → o_RValid and o_Err pulse together READ_LAT cycles later with o_RData=0.
    - Write and read in the same cycle: the write executes; the read address is captured into the pending slot → PEND.
  - PEND: o_MemBusy=1; the pending read is issued → IDLE. Its o_RValid arrives READ_LAT cycles after the PEND cycle.
- Back-to-back legal reads in IDLE: one per cycle, fully pipelined.
- Read-after-write to the same address in a later cycle returns the new data. Same-cycle collisions are resolved by PEND ordering (write first), so no stale reads occur.
- i_WStrb=0 with a legal address: no memory change, no error.
- Requests while o_MemBusy=1 are ignored: no write, no o_RValid, no o_Err. The master must hold or reissue them.
- o_Err is the OR of the write-error pulse and the read-error pulse. If both fall in the same cycle it is a single pulse.
- Reset mid-operation:
  - in-flight reads are dropped and produce no o_RValid;
  - the pending read is dropped;
  - CLEAR restarts from index 0;
  - writes already committed are overwritten only if CLEAR_ON_RST=1.

Decomposition:
- Shared package bram_bus_pkg:
  - FSM state typedef {CLEAR, IDLE, PEND}
  - localparams BYTES = DATA_W/8, OFS_W = log2(BYTES), IDX_W = log2(DEPTH)
  - address-decode function returning {legal, index}
- One sub-module, bram_sp_bytewe: an inferred single-port RAM with per-byte write enable and a registered read (latency 1). The wrapper adds the optional second output stage when READ_LAT=2.

Test Plan:
- Reset release with CLEAR_ON_RST=1, DEPTH=16 → o_MemBusy high for 16 cycles after reset deasserts. A subsequent read of 0x3C returns 0x0000_0000 with o_RValid and no o_Err.
- Write 0xDEADBEEF to 0x10 with strobe 4'b1111, then write 0x000000AA to 0x10 with strobe 4'b0001, then read 0x10 → o_RData = 0xDEADBEAA, valid READ_LAT cycles after the read; repeat with READ_LAT=2.
- Same-cycle write of 0x12345678 to 0x20 and read of 0x20 → o_MemBusy=1 for one cycle, then o_RValid returns 0x12345678.
- Write to 0x03 (misaligned) and to BASE+DEPTH*4 → o_Err pulses one cycle later and memory is unchanged. Read of BASE+DEPTH*4 → o_RValid and o_Err together with o_RData=0.
- Reads of 0x0, 0x4, 0x8 on consecutive cycles → three consecutive o_RValid pulses with the correct data in order.
- Assert i_Rst while a read is in flight and during CLEAR → no o_RValid for the dropped read; CLEAR restarts and o_MemBusy stays high for the full DEPTH cycles.

Source files
------------

// File: rtl/bram_bus_pkg.sv
// Shared types and address decode for the block-RAM bus slave.
package bram_bus_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        PEND
    } state_t;

    typedef struct packed {
        logic        legal;
        logic [31:0] index;
    } decode_t;

    // Addresses are widened to 64 bits so any ADDR_W up to 64 decodes without overflow.
    function automatic decode_t decode_addr(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] span,
        input int          ofs_w
    );
        decode_t     d;
        logic [63:0] off;
        logic [63:0] mask;
        off     = addr - base;
        mask    = (64'd1 << ofs_w) - 64'd1;
        d.legal = (addr >= base) && (off < span) && ((off & mask) == 64'd0);
        d.index = 32'(off >> ofs_w);
        return d;
    endfunction

endpackage

// File: rtl/bram_bus_wrapper_ram.sv
// Inferred single-port RAM with per-byte write enables and a registered read.
module bram_sp_bytewe #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4096,
    localparam int BYTES  = DATA_W / 8,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [BYTES-1:0]  we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // NOTE: the array and read register carry no reset so the tools can map them onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    // A cycle with any lane enabled is a write; rdata only moves on pure reads.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (we[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            if (we == '0) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bram_bus_wrapper.sv
// Block-RAM bus slave: byte strobes, address decode with error pulses,
// one-deep pending read for read/write collisions, and optional zero-fill after reset.
module bram_bus_wrapper
    import bram_bus_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int                DEPTH        = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                READ_LAT     = 1,
    parameter int                CLEAR_ON_RST = 1
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_WEnable,
    input  logic [ADDR_W-1:0]   i_WAddr,
    input  logic [DATA_W-1:0]   i_WData,
    input  logic [DATA_W/8-1:0] i_WStrb,
    input  logic                i_REnable,
    input  logic [ADDR_W-1:0]   i_RAddr,
    output logic [DATA_W-1:0]   o_RData,
    output logic                o_RValid,
    output logic                o_Err,
    output logic                o_MemBusy
);

    localparam int          BYTES  = DATA_W / 8;
    localparam int          OFS_W  = $clog2(BYTES);
    localparam int          IDX_W  = $clog2(DEPTH);
    localparam logic [63:0] BASE64 = 64'(BASE_ADDR);
    localparam logic [63:0] SPAN   = 64'(DEPTH) * 64'(BYTES);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_idx_q;
    logic              pend_legal_q;
    logic [IDX_W-1:0]  pend_idx_q;
    logic              s1_valid_q, s1_legal_q;
    logic              wr_err_q;

    decode_t           w_dec, r_dec;
    logic [IDX_W-1:0]  w_idx, r_idx;

    logic              ram_en;
    logic [BYTES-1:0]  ram_we;
    logic [IDX_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              rd_issue, rd_issue_legal, pend_capture, wr_err_d;
    logic [DATA_W-1:0] rd_data_now;

    // A legal index is always below DEPTH, so masking only drops bits that are already zero.
    assign w_dec = decode_addr(64'(i_WAddr), BASE64, SPAN, OFS_W);
    assign r_dec = decode_addr(64'(i_RAddr), BASE64, SPAN, OFS_W);
    assign w_idx = IDX_W'(w_dec.index & 32'(DEPTH - 1));
    assign r_idx = IDX_W'(r_dec.index & 32'(DEPTH - 1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        ram_en         = 1'b0;
        ram_we         = '0;
        ram_addr       = r_idx;
        ram_wdata      = i_WData;
        rd_issue       = 1'b0;
        rd_issue_legal = 1'b0;
        pend_capture   = 1'b0;
        wr_err_d       = 1'b0;
        case (state_q)
            CLEAR: begin
                ram_en    = 1'b1;
                ram_we    = '1;
                ram_addr  = clr_idx_q;
                ram_wdata = '0;
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (i_WEnable) begin
                    if (w_dec.legal) begin
                        ram_en   = (i_WStrb != '0);
                        ram_we   = i_WStrb;
                        ram_addr = w_idx;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                    // The write owns the single port this cycle; the read waits one cycle in PEND.
                    if (i_REnable) begin
                        pend_capture = 1'b1;
                        state_d      = PEND;
                    end
                end else if (i_REnable) begin
                    rd_issue       = 1'b1;
                    rd_issue_legal = r_dec.legal;
                    ram_en         = r_dec.legal;
                    ram_addr       = r_idx;
                end
            end
            PEND: begin
                rd_issue       = 1'b1;
                rd_issue_legal = pend_legal_q;
                ram_en         = pend_legal_q;
                ram_addr       = pend_idx_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_Rst) begin
            ram_en = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
            clr_idx_q    <= '0;
            pend_legal_q <= 1'b0;
            pend_idx_q   <= '0;
            s1_valid_q   <= 1'b0;
            s1_legal_q   <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                clr_idx_q <= clr_idx_q + IDX_W'(1);
            end
            if (pend_capture) begin
                pend_legal_q <= r_dec.legal;
                pend_idx_q   <= r_idx;
            end
            s1_valid_q <= rd_issue;
            s1_legal_q <= rd_issue_legal;
            wr_err_q   <= wr_err_d;
        end
    end

    bram_sp_bytewe #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (i_Clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign rd_data_now = s1_legal_q ? ram_rdata : '0;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              s2_valid_q, s2_err_q;
            logic [DATA_W-1:0] s2_data_q;

            always_ff @(posedge i_Clk) begin
                if (i_Rst) begin
                    s2_valid_q <= 1'b0;
                    s2_err_q   <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    s2_err_q   <= s1_valid_q & ~s1_legal_q;
                    if (s1_valid_q) begin
                        s2_data_q <= rd_data_now;
                    end
                end
            end

            assign o_RValid = s2_valid_q & ~i_Rst;
            assign o_RData  = s2_data_q;
            assign o_Err    = (wr_err_q | s2_err_q) & ~i_Rst;
        end else begin : g_lat1
            logic              rd_fire;
            logic [DATA_W-1:0] hold_q;

            // Holding the last returned word keeps o_RData stable between valid pulses.
            assign rd_fire = s1_valid_q & ~i_Rst;

            always_ff @(posedge i_Clk) begin
                if (i_Rst) begin
                    hold_q <= '0;
                end else if (s1_valid_q) begin
                    hold_q <= rd_data_now;
                end
            end

            assign o_RValid = rd_fire;
            assign o_RData  = rd_fire ? rd_data_now : hold_q;
            assign o_Err    = (wr_err_q | (rd_fire & ~s1_legal_q)) & ~i_Rst;
        end
    endgenerate

    assign o_MemBusy = i_Rst | (state_q != IDLE);

endmodule
